// File: rtl/qmerge.sv
// Merges two eot-framed queue streams into one ctrl-tagged stream, locking per transaction.
// Optional build macro QMERGE_RR_EN: round-robin IDLE tie-break (otherwise din0 always wins ties).
module qmerge #(
    parameter int W_DATA = 16,
    parameter int LVL    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LVL+W_DATA-1:0] din0_data,
    input  logic                  din0_valid,
    output logic                  din0_ready,
    input  logic [LVL+W_DATA-1:0] din1_data,
    input  logic                  din1_valid,
    output logic                  din1_ready,
    output logic [LVL+W_DATA:0]   dout_data,
    output logic                  dout_valid,
    input  logic                  dout_ready
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOCK0 = 2'd1;
    localparam logic [1:0] LOCK1 = 2'd2;

    logic [1:0]            state;
    logic                  tie_pick1;
    logic                  grant0;
    logic                  grant1;
    logic                  space;
    logic                  load;
    logic                  txn_end;
    logic [LVL+W_DATA-1:0] sel_data;

`ifdef QMERGE_RR_EN
    logic rr;

    // rr points at the input that should win the next IDLE tie
    always_ff @(posedge clk) begin
        if (rst)
            rr <= 1'b0;
        else if (load && txn_end)
            rr <= grant0;
    end

    assign tie_pick1 = rr;
`else
    assign tie_pick1 = 1'b0;
`endif

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        case (state)
            LOCK0: grant0 = 1'b1;
            LOCK1: grant1 = 1'b1;
            default: begin
                if (din0_valid && din1_valid) begin
                    grant1 = tie_pick1;
                    grant0 = !tie_pick1;
                end else begin
                    grant0 = din0_valid;
                    grant1 = din1_valid && !din0_valid;
                end
            end
        endcase
    end

    assign space      = !dout_valid || dout_ready;
    assign din0_ready = grant0 && space;
    assign din1_ready = grant1 && space;
    assign load       = (din0_valid && din0_ready) || (din1_valid && din1_ready);
    assign sel_data   = grant1 ? din1_data : din0_data;
    assign txn_end    = sel_data[LVL+W_DATA-1];

    // The lock is taken on any non-final item and released only by the outermost eot
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else if (load)
            state <= txn_end ? IDLE : (grant1 ? LOCK1 : LOCK0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_valid <= 1'b0;
            dout_data  <= '0;
        end else if (load) begin
            dout_valid <= 1'b1;
            dout_data  <= {sel_data[LVL+W_DATA-1:W_DATA], grant1, sel_data[W_DATA-1:0]};
        end else if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
            dout_data  <= '0;
        end
    end

endmodule

// File: doc/qmerge.md
# qmerge

Merges two queue streams into one union-tagged queue stream. Each output item carries a `ctrl` bit naming its source input, so a downstream filter keyed on `ctrl` can recover either stream. Whole transactions are never interleaved: an input keeps the grant from its first item until its outermost end-of-transaction item is accepted. The block sits upstream of the per-field filters, on the producing side of the tagged-queue interface.

## Interface
- `W_DATA`, 16, payload width of each input item.
- `LVL`, 1, number of eot bits (queue depth levels); must be ≥ 1.
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `din0`  dti.consumer  `LVL+W_DATA`  input queue 0; data = {eot[LVL-1:0], data[W_DATA-1:0]}, tagged ctrl=0.
- `din1`  dti.consumer  `LVL+W_DATA`  input queue 1; same format, tagged ctrl=1.
- `dout`  dti.producer  `LVL+1+W_DATA`  output; data = {eot[LVL-1:0], ctrl, data[W_DATA-1:0]}.

## Operation
- Arbiter FSM states:
  - IDLE: no grant held.
  - LOCK0: din0 granted.
  - LOCK1: din1 granted.
- Transaction end: an accepted item with eot[LVL-1]=1.
- IDLE arbitration is combinational in the same cycle.
  - Only one input valid: that input is granted.
  - Both valid: the round-robin pointer `rr` picks the winner.
- When the granted item is accepted:
  - Not a transaction end: go to LOCKk.
  - Transaction end: stay in or return to IDLE, and set `rr` to the other input.
- In LOCKk, only dink is granted; the other input's ready=0 regardless of its valid.
- Output register: one entry {eot, ctrl, data} plus a valid flag.
  - Load when the granted input is valid and (register empty or dout handshake this cycle).
  - `ctrl` = index of the granted input; eot and data are copied unchanged.
- Handshake-only cycle (dout handshake with no load): clear the valid flag and zero the register.
- dink.ready = granted(k) && (register empty || dout.ready).
- dout.valid = register valid flag.
- Reset values:
  - dout.valid=0, dout.data=0.
  - FSM=IDLE, rr=0 (din0 wins the first tie).
  - din0.ready and din1.ready follow their combinational equations from the reset state.
- Reset mid-transaction drops the lock and the buffered item; nothing is replayed after reset.

## Timing
- Latency: 1 cycle from din handshake to dout.valid.
- Throughput: 1 item/cycle while dout.ready=1.
- din ready depends combinationally on dout.ready. There is no combinational path from din data to dout.
- dout.data is stable while dout.valid=1 and dout.ready=0. Producers must hold din data/valid until ready.
- A transaction-end item and the next transaction's first item may be accepted on consecutive cycles. In the cycle after a transaction end, the FSM is in IDLE and arbitrates using the updated `rr`.
- Simultaneous dout handshake and din accept: the register reloads with no bubble, and the valid flag stays 1.
- An input asserting valid while the other input holds the lock waits unboundedly; the lock holder's valid gaps do not release the lock.

## Configuration
- `QMERGE_RR_EN`
  - Defined: round-robin tie-break as above.
  - Undefined: fixed priority; din0 always wins IDLE ties, and the `rr` register is not built.
- Locking, tagging and buffering are identical in both builds.

## Test plan
- Single stream: din0 sends 0x11, 0x22, 0x33 (eot on 0x33), dout.ready=1.
  - dout shows {0,0,0x11}, {0,0,0x22}, {1,0,0x33} on consecutive cycles, 1 cycle after each accept.
- Tie after reset: din0 and din1 both valid with single-item transactions 0xA0 and 0xB0, held valid.
  - Output order is A0(ctrl0), B0(ctrl1), A0, B0, …
  - With `QMERGE_RR_EN` undefined: A0, A0, …, and din1.ready stays 0.
- Lock: din0 starts a 3-item transaction; din1 asserts valid with 0xC5 during item 2, and din0 drops valid for 2 cycles before item 3.
  - din1.ready=0 until din0's eot item is accepted.
  - 0xC5 (ctrl1) follows immediately after din0's eot item.
- Backpressure: hold dout.ready=0 for 4 cycles with din1 sending 0x5A.
  - dout holds {0,1,0x5A}; din ready=0 after the first accept.
  - When dout.ready rises, output continues with no loss or duplication.
- LVL=2: din1 sends eot=01 then eot=10.
  - Lock is held after eot=01 and released after eot=10.
  - eot bits are passed through unchanged.
- Reset mid-transaction: pulse rst after din0's first non-eot item.
  - Next cycle: dout.valid=0, dout.data=0, FSM IDLE.
  - With both inputs then valid, din0 wins because rr=0.
